// File: rtl/bitnet_axil_pkg.sv
// Shared constants for the BitNet AXI4-Lite register slave: register map,
// identification words, CTRL/STATUS bit positions and AXI response codes.
package bitnet_axil_pkg;

   localparam logic [7:0] OFF_CTRL     = 8'h00;
   localparam logic [7:0] OFF_STATUS   = 8'h04;
   localparam logic [7:0] OFF_THRESH   = 8'h08;
   localparam logic [7:0] OFF_RESULT   = 8'h0C;
   localparam logic [7:0] OFF_VERSION  = 8'h10;
   localparam logic [7:0] OFF_PHOENIX  = 8'h14;
   localparam logic [7:0] OFF_LOAD_PTR = 8'h18;
   localparam logic [7:0] BASE_INPUT   = 8'h40;
   localparam logic [7:0] BASE_WEIGHT  = 8'h80;

   localparam logic [31:0] VERSION_VAL = 32'h0002_0000;
   localparam logic [31:0] PHOENIX_VAL = 32'd999;
   localparam logic [31:0] BAD_RDATA   = 32'hDEAD_BEEF;

   localparam int CTRL_START  = 0;
   localparam int CTRL_LOAD   = 1;
   localparam int CTRL_AUTO   = 2;
   localparam int CTRL_IRQ_EN = 3;

   localparam int ST_READY     = 0;
   localparam int ST_RES_VALID = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_LOAD_DONE = 3;
   localparam int ST_ERR       = 4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/bitnet_axil_load_ptr.sv
// Weight-load pointer: layer/row counter that can be loaded directly or
// stepped row-first, with the row carrying into the layer and both wrapping.
module bitnet_axil_load_ptr
   import bitnet_axil_pkg::*;
#(
   parameter int LAYERS  = 2,
   parameter int ROWS    = 16,
   parameter int LAYER_W = (LAYERS > 1) ? $clog2(LAYERS) : 1,
   parameter int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic               i_clk,
   input  logic               i_srst,
   input  logic               i_load,
   input  logic [LAYER_W-1:0] i_layer,
   input  logic [ROW_W-1:0]   i_row,
   input  logic               i_inc,
   output logic [LAYER_W-1:0] o_layer,
   output logic [ROW_W-1:0]   o_row
);

   localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(LAYERS - 1);
   localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);

   logic [LAYER_W-1:0] r_layer;
   logic [ROW_W-1:0]   r_row;

   // A direct load takes priority over a step issued in the same cycle
   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         r_layer <= '0;
         r_row   <= '0;
      end else if (i_load) begin
         r_layer <= i_layer;
         r_row   <= i_row;
      end else if (i_inc) begin
         if (r_row == LAST_ROW) begin
            r_row   <= '0;
            r_layer <= (r_layer == LAST_LAYER) ? '0 : r_layer + 1'b1;
         end else begin
            r_row <= r_row + 1'b1;
         end
      end
   end

   assign o_layer = r_layer;
   assign o_row   = r_row;

endmodule

// File: rtl/bitnet_axil_regs.sv
// AXI4-Lite register slave fronting the BitNet hybrid inference engine:
// control/status, thresholds, result capture and input/weight vector windows.
module bitnet_axil_regs
   import bitnet_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 8,
   parameter int VEC_W  = 54,
   parameter int RES_W  = 3,
   parameter int LAYERS = 2,
   parameter int ROWS   = 16,
   parameter int TH1_W  = 6,
   parameter int TH2_W  = 5,
   localparam int NW      = (VEC_W + 31) / 32,
   localparam int LAYER_W = (LAYERS > 1) ? $clog2(LAYERS) : 1,
   localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            eng_load_weight,
   output logic [LAYER_W-1:0]              eng_load_layer,
   output logic [ROW_W-1:0]                eng_load_row,
   output logic [VEC_W-1:0]                eng_load_data,
   input  logic                            eng_load_done,
   output logic                            eng_start,
   output logic [VEC_W-1:0]                eng_input_vec,
   output logic [TH1_W-1:0]                eng_threshold_l1,
   output logic [TH2_W-1:0]                eng_threshold_l2,
   input  logic [RES_W-1:0]                eng_result,
   input  logic                            eng_result_valid,
   input  logic                            eng_ready,
   output logic                            irq
);

   if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
      $error("bitnet_axil_regs supports only a 32-bit AXI data bus");
   end

   // Bits of the top window word at or above VEC_W are forced to zero
   localparam logic [NW*32-1:0] VEC_MASK = (NW*32)'({VEC_W{1'b1}});
   localparam logic [4:0]       NW_L     = 5'(NW);

   logic                          r_aw_full, r_w_full, r_bvalid, r_rvalid;
   logic [C_S_AXI_ADDR_WIDTH-1:0] r_aw_addr;
   logic [31:0]                   r_wdata, r_rdata;
   logic [3:0]                    r_wstrb;
   logic [1:0]                    r_bresp, r_rresp;
   logic                          r_auto_load, r_irq_en, r_irq;
   logic                          r_res_valid, r_load_done, r_err;
   logic                          r_eng_start, r_load_pulse;
   logic [LAYER_W-1:0]            r_load_layer;
   logic [ROW_W-1:0]              r_load_row;
   logic [TH1_W-1:0]              r_th1;
   logic [TH2_W-1:0]              r_th2;
   logic [RES_W-1:0]              r_result;
   logic [NW*32-1:0]              r_input, r_weight;

   function automatic logic in_win(input logic [7:0] a, input logic [7:0] base);
      return (a[7:6] == base[7:6]) && ({1'b0, a[5:2]} < NW_L);
   endfunction

   logic [7:0]         w_wa, w_ra;
   logic [3:0]         w_widx, w_ridx;
   logic               w_wr_ctrl, w_wr_status, w_wr_thresh, w_wr_in, w_wr_wt, w_wr_ok;
   logic               w_commit, w_do, w_w1c;
   logic               w_start_req, w_ctrl_load, w_auto_load, w_ptr_load;
   logic [31:0]        w_bmask;
   logic [LAYER_W-1:0] w_ptr_layer, w_ptr_layer_new;
   logic [ROW_W-1:0]   w_ptr_row, w_ptr_row_new;
   logic               w_unused;

   assign w_wa        = {r_aw_addr[7:2], 2'b00};
   assign w_widx      = r_aw_addr[5:2];
   assign w_wr_ctrl   = (w_wa == OFF_CTRL);
   assign w_wr_status = (w_wa == OFF_STATUS);
   assign w_wr_thresh = (w_wa == OFF_THRESH);
   assign w_wr_in     = in_win(w_wa, BASE_INPUT);
   assign w_wr_wt     = in_win(w_wa, BASE_WEIGHT);
   assign w_wr_ok     = w_wr_ctrl | w_wr_status | w_wr_thresh | w_wr_in | w_wr_wt;

   assign w_commit    = r_aw_full & r_w_full & ~r_bvalid;
   assign w_do        = w_commit & w_wr_ok;
   assign w_bmask     = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
   assign w_w1c       = w_do & w_wr_status & r_wstrb[0];
   assign w_start_req = w_do & w_wr_ctrl & r_wstrb[0] & r_wdata[CTRL_START];
   assign w_ctrl_load = w_do & w_wr_ctrl & r_wstrb[0] & r_wdata[CTRL_LOAD];
   assign w_auto_load = w_do & w_wr_wt & r_auto_load & (w_widx == 4'(NW - 1));
   assign w_ptr_load  = w_do & w_wr_ctrl & (r_wstrb[0] | r_wstrb[1]);

   assign w_ptr_layer_new = r_wstrb[0] ? r_wdata[4 +: LAYER_W] : w_ptr_layer;
   assign w_ptr_row_new   = r_wstrb[1] ? r_wdata[8 +: ROW_W]   : w_ptr_row;

   bitnet_axil_load_ptr #(
      .LAYERS (LAYERS),
      .ROWS   (ROWS),
      .LAYER_W(LAYER_W),
      .ROW_W  (ROW_W)
   ) u_load_ptr (
      .i_clk  (S_AXI_ACLK),
      .i_srst (S_AXI_ARESET),
      .i_load (w_ptr_load),
      .i_layer(w_ptr_layer_new),
      .i_row  (w_ptr_row_new),
      .i_inc  (w_auto_load),
      .o_layer(w_ptr_layer),
      .o_row  (w_ptr_row)
   );

   // Word views of the vector windows, padded to the full 16-word window
   logic [31:0]      w_in_words [16];
   logic [31:0]      w_wt_words [16];
   logic [NW*32-1:0] w_input_next, w_weight_next;

   for (genvar gi = 0; gi < 16; gi++) begin : g_word
      if (gi < NW) begin : g_used
         assign w_in_words[gi] = r_input[gi*32 +: 32];
         assign w_wt_words[gi] = r_weight[gi*32 +: 32];
         assign w_input_next[gi*32 +: 32] = (w_do && w_wr_in && w_widx == 4'(gi)) ?
            ((w_in_words[gi] & ~w_bmask) | (r_wdata & w_bmask)) & VEC_MASK[gi*32 +: 32] :
            w_in_words[gi];
         assign w_weight_next[gi*32 +: 32] = (w_do && w_wr_wt && w_widx == 4'(gi)) ?
            ((w_wt_words[gi] & ~w_bmask) | (r_wdata & w_bmask)) & VEC_MASK[gi*32 +: 32] :
            w_wt_words[gi];
      end else begin : g_pad
         assign w_in_words[gi] = '0;
         assign w_wt_words[gi] = '0;
      end
   end

   assign S_AXI_AWREADY = ~r_aw_full & ~r_bvalid;
   assign S_AXI_WREADY  = ~r_w_full & ~r_bvalid;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = ~r_rvalid;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_aw_full <= 1'b0;
         r_aw_addr <= '0;
         r_w_full  <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            r_aw_full <= 1'b1;
            r_aw_addr <= S_AXI_AWADDR;
         end
         if (S_AXI_WVALID && S_AXI_WREADY) begin
            r_w_full <= 1'b1;
            r_wdata  <= S_AXI_WDATA;
            r_wstrb  <= S_AXI_WSTRB;
         end
         if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
         end
         if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid  <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_auto_load  <= 1'b0;
         r_irq_en     <= 1'b0;
         r_irq        <= 1'b0;
         r_res_valid  <= 1'b0;
         r_load_done  <= 1'b0;
         r_err        <= 1'b0;
         r_eng_start  <= 1'b0;
         r_load_pulse <= 1'b0;
         r_load_layer <= '0;
         r_load_row   <= '0;
         r_th1        <= TH1_W'(5);
         r_th2        <= TH2_W'(2);
         r_result     <= '0;
         r_input      <= '0;
         r_weight     <= '0;
      end else begin
         r_input      <= w_input_next;
         r_weight     <= w_weight_next;
         r_eng_start  <= w_start_req & eng_ready;
         r_load_pulse <= w_ctrl_load | w_auto_load;
         // Auto-load reports the pointer as it was before the increment
         if (w_ctrl_load || w_auto_load) begin
            r_load_layer <= w_ctrl_load ? w_ptr_layer_new : w_ptr_layer;
            r_load_row   <= w_ctrl_load ? w_ptr_row_new   : w_ptr_row;
         end
         if (w_do && w_wr_ctrl && r_wstrb[0]) begin
            r_auto_load <= r_wdata[CTRL_AUTO];
            r_irq_en    <= r_wdata[CTRL_IRQ_EN];
         end
         if (w_do && w_wr_thresh && r_wstrb[0]) r_th1 <= r_wdata[TH1_W-1:0];
         if (w_do && w_wr_thresh && r_wstrb[1]) r_th2 <= r_wdata[8 +: TH2_W];
         if (eng_result_valid) r_result <= eng_result;
         // New events win over a W1C landing in the same cycle
         r_res_valid <= eng_result_valid | (r_res_valid & ~(w_w1c & r_wdata[ST_RES_VALID]));
         r_load_done <= eng_load_done | (r_load_done & ~(w_w1c & r_wdata[ST_LOAD_DONE]));
         r_err       <= (w_start_req & ~eng_ready) | (r_err & ~(w_w1c & r_wdata[ST_ERR]));
         r_irq       <= r_irq_en & (r_res_valid | r_load_done | r_err);
      end
   end

   logic [31:0] w_rd_data;
   logic [1:0]  w_rd_resp;

   assign w_ra   = {S_AXI_ARADDR[7:2], 2'b00};
   assign w_ridx = S_AXI_ARADDR[5:2];

   always_comb begin
      w_rd_data = BAD_RDATA;
      w_rd_resp = RESP_SLVERR;
      if (in_win(w_ra, BASE_INPUT)) begin
         w_rd_data = w_in_words[w_ridx];
         w_rd_resp = RESP_OKAY;
      end else if (in_win(w_ra, BASE_WEIGHT)) begin
         w_rd_data = w_wt_words[w_ridx];
         w_rd_resp = RESP_OKAY;
      end else begin
         case (w_ra)
            OFF_CTRL: begin
               w_rd_data              = '0;
               w_rd_data[CTRL_AUTO]   = r_auto_load;
               w_rd_data[CTRL_IRQ_EN] = r_irq_en;
               w_rd_data[7:4]         = 4'(w_ptr_layer);
               w_rd_data[15:8]        = 8'(w_ptr_row);
               w_rd_resp              = RESP_OKAY;
            end
            OFF_STATUS: begin
               w_rd_data               = '0;
               w_rd_data[ST_READY]     = eng_ready;
               w_rd_data[ST_RES_VALID] = r_res_valid;
               w_rd_data[ST_BUSY]      = ~eng_ready;
               w_rd_data[ST_LOAD_DONE] = r_load_done;
               w_rd_data[ST_ERR]       = r_err;
               w_rd_resp               = RESP_OKAY;
            end
            OFF_THRESH: begin
               w_rd_data              = '0;
               w_rd_data[TH1_W-1:0]   = r_th1;
               w_rd_data[8 +: TH2_W]  = r_th2;
               w_rd_resp              = RESP_OKAY;
            end
            OFF_RESULT: begin
               w_rd_data = 32'($signed(r_result));
               w_rd_resp = RESP_OKAY;
            end
            OFF_VERSION: begin
               w_rd_data = VERSION_VAL;
               w_rd_resp = RESP_OKAY;
            end
            OFF_PHOENIX: begin
               w_rd_data = PHOENIX_VAL;
               w_rd_resp = RESP_OKAY;
            end
            OFF_LOAD_PTR: begin
               w_rd_data = {16'd0, 8'(w_ptr_row), 4'd0, 4'(w_ptr_layer)};
               w_rd_resp = RESP_OKAY;
            end
            default: ;
         endcase
      end
   end

   // Read data is captured at the AR handshake, so a coincident W1C is not visible
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else if (S_AXI_ARVALID && !r_rvalid) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_data;
         r_rresp  <= w_rd_resp;
      end else if (r_rvalid && S_AXI_RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

   assign eng_start        = r_eng_start;
   assign eng_load_weight  = r_load_pulse;
   assign eng_load_layer   = r_load_layer;
   assign eng_load_row     = r_load_row;
   assign eng_load_data    = r_weight[VEC_W-1:0];
   assign eng_input_vec    = r_input[VEC_W-1:0];
   assign eng_threshold_l1 = r_th1;
   assign eng_threshold_l2 = r_th2;
   assign irq              = r_irq;

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, r_aw_addr, S_AXI_ARADDR};

endmodule

// File: tb/tb_bitnet_axil_regs.sv
// Directed bench for bitnet_axil_regs: AXI write/read sequences with
// hand-computed expectations for the register map and engine strobes.
module tb_bitnet_axil_regs;

   logic        clk = 1'b0;
   logic        srst;
   logic [7:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        eng_load_weight, eng_load_done, eng_start;
   logic [0:0]  eng_load_layer;
   logic [3:0]  eng_load_row;
   logic [53:0] eng_load_data, eng_input_vec;
   logic [5:0]  eng_threshold_l1;
   logic [4:0]  eng_threshold_l2;
   logic [2:0]  eng_result;
   logic        eng_result_valid, eng_ready, irq;

   int n_tests = 0;
   int n_fail  = 0;
   int n_start = 0;
   int n_load  = 0;
   logic [0:0]  ld_layer;
   logic [3:0]  ld_row;
   logic [53:0] ld_data;

   always #5 clk = ~clk;

   bitnet_axil_regs dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(srst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .eng_load_weight(eng_load_weight), .eng_load_layer(eng_load_layer), .eng_load_row(eng_load_row),
      .eng_load_data(eng_load_data), .eng_load_done(eng_load_done), .eng_start(eng_start),
      .eng_input_vec(eng_input_vec), .eng_threshold_l1(eng_threshold_l1),
      .eng_threshold_l2(eng_threshold_l2), .eng_result(eng_result),
      .eng_result_valid(eng_result_valid), .eng_ready(eng_ready), .irq(irq)
   );

   // Count strobe cycles and remember what the engine would have latched
   always @(posedge clk) begin
      if (eng_start) n_start++;
      if (eng_load_weight) begin
         n_load++;
         ld_layer = eng_load_layer;
         ld_row   = eng_load_row;
         ld_data  = eng_load_data;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output int lat);
      logic aw_done, w_done;
      int n;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1;
      aw_done = 1'b0; w_done = 1'b0; n = 0;
      while (!bvalid && n < 20) begin
         if (awvalid && awready) aw_done = 1'b1;
         if (wvalid && wready) w_done = 1'b1;
         tick();
         n++;
         if (aw_done) awvalid = 1'b0;
         if (w_done) wvalid = 1'b0;
      end
      lat = n;
      if (!bvalid) begin
         check("b_timeout", 64'(bvalid), 64'd1);
         awvalid = 1'b0; wvalid = 1'b0;
         resp = 2'b11;
      end else begin
         resp = bresp;
         bready = 1'b1;
         tick();
         bready = 1'b0;
      end
   endtask

   task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n;
      araddr = addr; arvalid = 1'b1; n = 0;
      while (!arready && n < 20) begin tick(); n++; end
      tick();
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin tick(); n++; end
      if (!rvalid) begin
         check("r_timeout", 64'(rvalid), 64'd1);
         data = 32'hX; resp = 2'b11;
      end else begin
         data = rdata; resp = rresp;
         rready = 1'b1;
         tick();
         rready = 1'b0;
      end
   endtask

   task automatic wr(input string tag, input logic [7:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic [1:0] exp_resp);
      logic [1:0] resp;
      int lat;
      axi_write(addr, data, strb, resp, lat);
      check({tag, "_bresp"}, 64'(resp), 64'(exp_resp));
   endtask

   task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] exp_data,
                     input logic [1:0] exp_resp);
      logic [31:0] data;
      logic [1:0]  resp;
      axi_read(addr, data, resp);
      check({tag, "_rdata"}, 64'(data), 64'(exp_data));
      check({tag, "_rresp"}, 64'(resp), 64'(exp_resp));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] resp;
      int lat, s0, l0;
      srst = 1'b1;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      wdata = '0; wstrb = '0;
      eng_load_done = 1'b0; eng_result = '0; eng_result_valid = 1'b0; eng_ready = 1'b1;
      repeat (3) tick();
      srst = 1'b0;
      tick();

      // Reset state
      check("rst_awready", 64'(awready), 64'd1);
      check("rst_wready", 64'(wready), 64'd1);
      check("rst_arready", 64'(arready), 64'd1);
      check("rst_bvalid", 64'(bvalid), 64'd0);
      check("rst_rvalid", 64'(rvalid), 64'd0);
      check("rst_irq", 64'(irq), 64'd0);
      check("rst_th_l1", 64'(eng_threshold_l1), 64'h05);
      check("rst_th_l2", 64'(eng_threshold_l2), 64'h02);
      rd("version", 8'h10, 32'h0002_0000, 2'b00);
      rd("phoenix", 8'h14, 32'h0000_03E7, 2'b00);
      rd("thresh_rst", 8'h08, 32'h0000_0205, 2'b00);
      rd("ptr_rst", 8'h18, 32'h0, 2'b00);

      // Simultaneous AW/W: BVALID two edges after issue
      axi_write(8'h08, 32'h0000_1F3F, 4'h1, resp, lat);
      check("aw_w_latency", 64'(lat), 64'd2);
      rd("thresh_b0", 8'h08, 32'h0000_023F, 2'b00);
      check("th_l1_out", 64'(eng_threshold_l1), 64'h3F);
      wr("thresh_b1", 8'h08, 32'h0000_1F00, 4'h2, 2'b00);
      rd("thresh_b1", 8'h08, 32'h0000_1F3F, 2'b00);

      // W three cycles ahead of AW, strobed to the low half-word
      wdata = 32'h1234_5678; wstrb = 4'h3; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      tick(); tick();
      check("w_first_no_early_b", 64'(bvalid), 64'd0);
      awaddr = 8'h40; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      check("w_first_b_not_yet", 64'(bvalid), 64'd0);
      tick();
      check("w_first_bvalid", 64'(bvalid), 64'd1);
      check("w_first_bresp", 64'(bresp), 64'd0);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check("w_first_single_b", 64'(bvalid), 64'd0);
      rd("input_w0", 8'h40, 32'h0000_5678, 2'b00);
      wr("input_w1", 8'h44, 32'hFFFF_FFFF, 4'hF, 2'b00);
      rd("input_w1_mask", 8'h44, 32'h003F_FFFF, 2'b00);
      check("input_vec", 64'(eng_input_vec), 64'h003F_FFFF_0000_5678);

      // START refused while engine busy
      eng_ready = 1'b0;
      s0 = n_start;
      wr("start_busy", 8'h00, 32'h1, 4'hF, 2'b00);
      tick();
      check("start_busy_no_pulse", 64'(n_start - s0), 64'd0);
      rd("status_err", 8'h04, 32'h0000_0014, 2'b00);
      wr("w1c_err", 8'h04, 32'h10, 4'h1, 2'b00);
      rd("status_err_clr", 8'h04, 32'h0000_0004, 2'b00);
      eng_ready = 1'b1;
      s0 = n_start;
      wr("start_ok", 8'h00, 32'h1, 4'hF, 2'b00);
      tick(); tick();
      check("start_one_pulse", 64'(n_start - s0), 64'd1);
      rd("status_ready", 8'h04, 32'h0000_0001, 2'b00);

      // AUTO_LOAD from the last row of the last layer wraps the pointer
      wr("ctrl_auto", 8'h00, 32'h0000_0F14, 4'hF, 2'b00);
      rd("ptr_set", 8'h18, 32'h0000_0F01, 2'b00);
      l0 = n_load;
      wr("weight_top", 8'h84, 32'hFFFF_FFFF, 4'hF, 2'b00);
      tick();
      check("auto_one_pulse", 64'(n_load - l0), 64'd1);
      check("auto_layer", 64'(ld_layer), 64'd1);
      check("auto_row", 64'(ld_row), 64'd15);
      check("auto_data", 64'(ld_data), 64'h003F_FFFF_0000_0000);
      rd("ptr_wrapped", 8'h18, 32'h0, 2'b00);

      // Explicit LOAD uses the pointer written in the same CTRL write
      l0 = n_load;
      wr("ctrl_load", 8'h00, 32'h0000_0302, 4'h3, 2'b00);
      tick();
      check("load_one_pulse", 64'(n_load - l0), 64'd1);
      check("load_layer", 64'(ld_layer), 64'd0);
      check("load_row", 64'(ld_row), 64'd3);

      // Result capture, sign extension and interrupt
      wr("ctrl_irq_en", 8'h00, 32'h08, 4'h1, 2'b00);
      check("irq_idle", 64'(irq), 64'd0);
      eng_result = 3'b110;
      eng_result_valid = 1'b1;
      tick();
      eng_result_valid = 1'b0;
      tick();
      check("irq_set", 64'(irq), 64'd1);
      rd("result_neg2", 8'h0C, 32'hFFFF_FFFE, 2'b00);
      rd("status_resv", 8'h04, 32'h0000_0003, 2'b00);
      wr("w1c_resv", 8'h04, 32'h02, 4'h1, 2'b00);
      tick();
      check("irq_clr", 64'(irq), 64'd0);

      // W1C colliding with a new result valid: set wins
      awaddr = 8'h04; wdata = 32'h02; wstrb = 4'h1;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      eng_result_valid = 1'b1;
      tick();
      eng_result_valid = 1'b0;
      check("collide_bvalid", 64'(bvalid), 64'd1);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      rd("status_set_wins", 8'h04, 32'h0000_0003, 2'b00);
      check("irq_set_wins", 64'(irq), 64'd1);
      wr("w1c_final", 8'h04, 32'h02, 4'h1, 2'b00);
      rd("status_final", 8'h04, 32'h0000_0001, 2'b00);

      // Error decoding
      rd("unmapped_3c", 8'h3C, 32'hDEAD_BEEF, 2'b10);
      rd("window_oob", 8'h48, 32'hDEAD_BEEF, 2'b10);
      wr("ro_result", 8'h0C, 32'h1234_5678, 4'hF, 2'b10);
      rd("result_kept", 8'h0C, 32'hFFFF_FFFE, 2'b00);

      // Reset discards a pending read response
      araddr = 8'h10; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      check("pend_rvalid", 64'(rvalid), 64'd1);
      srst = 1'b1;
      tick();
      check("rst_drops_rvalid", 64'(rvalid), 64'd0);
      check("rst_arready_back", 64'(arready), 64'd1);
      srst = 1'b0;
      tick();
      rd("thresh_after_rst", 8'h08, 32'h0000_0205, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
